// File: rtl/multicore_pkg.sv
// Shared defaults and helpers for the multicore I/O hub.
// Imported by the hub top and its FIFO.
package multicore_pkg;

  localparam int NCORES_DEF    = 4;
  localparam int DWIDTH_DEF    = 32;
  localparam int IN_DEPTH_DEF  = 8;
  localparam int OUT_DEPTH_DEF = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/hub_fifo.sv
// Synchronous first-word fall-through FIFO.
// Flags derive from the registered occupancy count.
module hub_fifo
  import multicore_pkg::*;
#(
  parameter int WIDTH = DWIDTH_DEF,
  parameter int DEPTH = IN_DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [WIDTH-1:0]        wdata,
  input  logic                    pop,
  output logic [WIDTH-1:0]        rdata,
  output logic                    empty,
  output logic                    full,
  output logic [clog2(DEPTH):0]   level
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];
  assign level   = count;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/multicore_io_hub.sv
// Hub fanning a host stream out to cores and merging results back.
// Two round-robin arbiters, each fronted or backed by a FIFO.
module multicore_io_hub
  import multicore_pkg::*;
#(
  parameter int NCORES    = NCORES_DEF,
  parameter int DWIDTH    = DWIDTH_DEF,
  parameter int IN_DEPTH  = IN_DEPTH_DEF,
  parameter int OUT_DEPTH = OUT_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DWIDTH-1:0]          in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NCORES-1:0]          req_in,
  output logic [DWIDTH-1:0]          core_data,
  output logic [NCORES-1:0]          core_valid,
  input  logic [NCORES-1:0]          out_en,
  input  logic [NCORES*DWIDTH-1:0]   io_out,
  output logic [NCORES-1:0]          out_ack,
  output logic [DWIDTH-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [clog2(IN_DEPTH):0]   in_level,
  output logic [clog2(OUT_DEPTH):0]  out_level
);

  localparam int PW = clog2(NCORES);

  function automatic logic [PW-1:0] rr_pick(
    input logic [NCORES-1:0] req,
    input logic [PW-1:0]     ptr
  );
    logic [PW-1:0] pick;
    logic          found;
    int            idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < NCORES; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NCORES) idx = idx - NCORES;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
    return pick;
  endfunction

  function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] p);
    return (p == PW'(NCORES-1)) ? '0 : p + 1'b1;
  endfunction

  logic              in_push;
  logic              in_grant;
  logic              in_empty;
  logic              in_full;
  logic [DWIDTH-1:0] in_head;
  logic [PW-1:0]     in_ptr;
  logic [PW-1:0]     in_pick;

  assign in_ready = !rst && !in_full;
  assign in_push  = in_valid && in_ready;
  assign in_grant = !rst && !in_empty && (|req_in);
  assign in_pick  = rr_pick(req_in, in_ptr);

  hub_fifo #(
    .WIDTH (DWIDTH),
    .DEPTH (IN_DEPTH)
  ) u_in_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_push),
    .wdata (in_data),
    .pop   (in_grant),
    .rdata (in_head),
    .empty (in_empty),
    .full  (in_full),
    .level (in_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      in_ptr     <= '0;
      core_valid <= '0;
      core_data  <= '0;
    end else begin
      core_valid <= '0;
      if (in_grant) begin
        core_valid <= NCORES'(1) << in_pick;
        core_data  <= in_head;
        in_ptr     <= rr_next(in_pick);
      end
    end
  end

  logic              out_accept;
  logic              out_pop;
  logic              out_empty;
  logic              out_full;
  logic [NCORES-1:0] out_elig;
  logic [PW-1:0]     out_ptr;
  logic [PW-1:0]     out_pick;
  logic [DWIDTH-1:0] out_word;

  // A core whose ack is showing this cycle still has the old word up.
  assign out_elig   = out_en & ~out_ack;
  assign out_accept = !rst && !out_full && (|out_elig);
  assign out_pick   = rr_pick(out_elig, out_ptr);
  assign out_word   = io_out[int'(out_pick)*DWIDTH +: DWIDTH];
  assign out_valid  = !rst && !out_empty;
  assign out_pop    = out_valid && out_ready;

  hub_fifo #(
    .WIDTH (DWIDTH),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (out_accept),
    .wdata (out_word),
    .pop   (out_pop),
    .rdata (out_data),
    .empty (out_empty),
    .full  (out_full),
    .level (out_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_ptr <= '0;
      out_ack <= '0;
    end else begin
      out_ack <= '0;
      if (out_accept) begin
        out_ack <= NCORES'(1) << out_pick;
        out_ptr <= rr_next(out_pick);
      end
    end
  end

endmodule

// File: tb/tb_multicore_io_hub.sv
// Directed bench for multicore_io_hub with a queue-based reference model.
module tb_multicore_io_hub;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int ID = 8;
  localparam int OD = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [W-1:0]   in_data;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   req_in;
  logic [W-1:0]   core_data;
  logic [N-1:0]   core_valid;
  logic [N-1:0]   out_en;
  logic [N*W-1:0] io_out;
  logic [N-1:0]   out_ack;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [3:0]     in_level;
  logic [3:0]     out_level;

  always #5 clk = ~clk;

  multicore_io_hub #(
    .NCORES    (N),
    .DWIDTH    (W),
    .IN_DEPTH  (ID),
    .OUT_DEPTH (OD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .req_in     (req_in),
    .core_data  (core_data),
    .core_valid (core_valid),
    .out_en     (out_en),
    .io_out     (io_out),
    .out_ack    (out_ack),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .in_level   (in_level),
    .out_level  (out_level)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  logic [W-1:0] m_inq[$];
  logic [W-1:0] m_outq[$];
  int           m_in_rr;
  int           m_out_rr;
  logic [N-1:0] m_cv;
  logic [N-1:0] m_ack;
  logic [W-1:0] m_cd;
  bit           m_live = 0;
  int           m_isz;
  int           m_osz;
  int           m_c;

  function automatic int rr(input logic [N-1:0] req, input int start);
    for (int k = 0; k < N; k++)
      if (req[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_inq.delete();
      m_outq.delete();
      m_in_rr  = 0;
      m_out_rr = 0;
      m_cv     = '0;
      m_ack    = '0;
      m_cd     = '0;
      m_live   = 1;
    end else begin
      m_isz = m_inq.size();
      m_osz = m_outq.size();
      m_c = (m_isz > 0) ? rr(req_in, m_in_rr) : -1;
      m_cv = '0;
      if (m_c >= 0) begin
        m_cd = m_inq.pop_front();
        m_cv[m_c] = 1'b1;
        m_in_rr = (m_c + 1) % N;
      end
      if (in_valid && m_isz < ID) m_inq.push_back(in_data);
      if (out_ready && m_osz > 0) m_outq.delete(0);
      m_c = (m_osz < OD) ? rr(out_en & ~m_ack, m_out_rr) : -1;
      m_ack = '0;
      if (m_c >= 0) begin
        m_outq.push_back(io_out[m_c*W +: W]);
        m_ack[m_c] = 1'b1;
        m_out_rr = (m_c + 1) % N;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_live) begin
      chk("in_ready", in_ready, !rst && m_inq.size() < ID);
      chk("in_level", in_level, m_inq.size());
      chk("core_valid", core_valid, m_cv);
      if (m_cv != '0) chk("core_data", core_data, m_cd);
      chk("out_ack", out_ack, m_ack);
      chk("out_valid", out_valid, !rst && m_outq.size() > 0);
      chk("out_level", out_level, m_outq.size());
      if (!rst && m_outq.size() > 0)
        chk("out_data", out_data, m_outq[0]);
    end
  end

  int ck[N];
  int nres;

  task automatic drive_cores();
    for (int c = 0; c < N; c++) begin
      out_en[c] = (ck[c] < nres);
      io_out[c*W +: W] = W'(100 * (c + 1) + ck[c]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int c = 0; c < N; c++)
      if (out_ack[c]) ck[c]++;
    drive_cores();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [W-1:0] s1_exp[3];
  logic [W-1:0] s4_exp[8];
  logic [N-1:0] e;
  int           got;
  int           guard;

  initial begin
    s1_exp = '{32'd5, 32'hFFFF_FFFD, 32'd7};
    s4_exp = '{32'd100, 32'd200, 32'd300, 32'd400,
               32'd101, 32'd201, 32'd301, 32'd401};
    in_data   = '0;
    in_valid  = 1'b0;
    req_in    = '0;
    out_ready = 1'b0;
    io_out    = '0;
    out_en    = '0;
    nres      = 0;
    for (int c = 0; c < N; c++) ck[c] = 0;
    drive_cores();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_level", in_level, 0);
    chk("rst_out_level", out_level, 0);
    chk("rst_core_valid", core_valid, 0);
    chk("rst_out_ack", out_ack, 0);
    chk("rst_core_data", core_data, 0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1);

    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = s1_exp[i];
      tick();
    end
    in_valid = 1'b0;
    chk("s1_level3", in_level, 3);
    req_in = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s1_cv", core_valid, 4'b0001);
      chk("s1_data", core_data, s1_exp[i]);
      chk("s1_level", in_level, 2 - i);
    end
    req_in = '0;
    tick();
    chk("s1_idle", core_valid, 0);

    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = W'(10 + i);
      tick();
    end
    in_valid = 1'b0;
    req_in = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      tick();
      e = 4'b0001 << i;
      chk("s2_grant", core_valid, e);
      chk("s2_data", core_data, 10 + i);
    end
    tick();
    chk("s2_empty", core_valid, 0);
    in_valid = 1'b1;
    in_data  = 32'd14;
    tick();
    in_valid = 1'b0;
    chk("s2_nobypass", core_valid, 0);
    tick();
    chk("s2_wrap", core_valid, 4'b0001);
    chk("s2_wrap_data", core_data, 14);
    req_in = '0;
    tick();

    req_in   = 4'b0010;
    in_valid = 1'b1;
    in_data  = 32'd9;
    tick();
    in_valid = 1'b0;
    chk("s3_nobypass", core_valid, 0);
    tick();
    chk("s3_cv", core_valid, 4'b0010);
    chk("s3_data", core_data, 9);
    req_in = '0;
    tick();

    nres = 3;
    drive_cores();
    repeat (8) tick();
    chk("s4_full", out_level, 8);
    repeat (3) begin
      tick();
      chk("s4_silent", out_ack, 0);
    end
    chk("s4_level", out_level, 8);
    out_ready = 1'b1;
    got   = 0;
    guard = 0;
    while (got < 12 && guard < 60) begin
      if (out_valid) begin
        if (got < 8) chk("s4_order", out_data, s4_exp[got]);
        got++;
      end
      tick();
      guard++;
    end
    chk("s4_drained", got, 12);
    out_ready = 1'b0;
    tick();

    for (int c = 0; c < N; c++) ck[c] = 0;
    nres = 1;
    drive_cores();
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = W'(i + 1);
      if (i == 3) req_in = 4'b0001;
      tick();
    end
    in_valid = 1'b0;
    chk("s5_in_half", in_level, 3);
    chk("s5_out_half", out_level, 4);
    chk("s5_cv_flight", core_valid, 4'b0001);
    chk("s5_ack_flight", |out_ack, 1);
    rst = 1'b1;
    tick();
    chk("s5_in_level", in_level, 0);
    chk("s5_out_level", out_level, 0);
    chk("s5_cv", core_valid, 0);
    chk("s5_ack", out_ack, 0);
    chk("s5_in_ready", in_ready, 0);
    chk("s5_out_valid", out_valid, 0);
    chk("s5_core_data", core_data, 0);
    tick();
    chk("s5_cv_hold", core_valid, 0);
    rst    = 1'b0;
    req_in = '0;
    #1;
    chk("s5_rel_ready", in_ready, 1);
    tick();
    chk("s5_post_ready", in_ready, 1);
    chk("s5_post_cv", core_valid, 0);
    chk("s5_post_ack", out_ack, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicore_io_hub.md
MULTICORE_IO_HUB -- requirements
Module: multicore_io_hub

Interface
REQ-001 SHALL have parameter NCORES, default 4: number of attached cores, range 2..16.
REQ-002 SHALL have parameter DWIDTH, default 32: signed sample width.
REQ-003 SHALL have parameter IN_DEPTH, default 8: input FIFO entries, power of 2.
REQ-004 SHALL have parameter OUT_DEPTH, default 8: output FIFO entries, power of 2.
REQ-005 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have port in_data  in  DWIDTH  host sample stream.
REQ-008 SHALL have port in_valid  in  1  host word present.
REQ-009 SHALL have port in_ready  out  1  input FIFO can accept.
REQ-010 SHALL have port req_in  in  NCORES  per-core request for next input word.
REQ-011 SHALL have port core_data  out  DWIDTH  word delivered to the granted core.
REQ-012 SHALL have port core_valid  out  NCORES  one-hot delivery strobe.
REQ-013 SHALL have port out_en  in  NCORES  per-core result-pending flag.
REQ-014 SHALL have port io_out  in  NCORES*DWIDTH  per-core results; core i at bits [i*DWIDTH +: DWIDTH].
REQ-015 SHALL have port out_ack  out  NCORES  one-hot result-accepted strobe.
REQ-016 SHALL have port out_data  out  DWIDTH  merged result stream, first-word fall-through.
REQ-017 SHALL have port out_valid  out  1  merged word present.
REQ-018 SHALL have port out_ready  in  1  sink accepts word.
REQ-019 SHALL have ports in_level and out_level  out  clog2(depth)+1  FIFO occupancy.

Function
REQ-020 SHALL push in_data into the input FIFO when in_valid && in_ready; in_ready = !in_full.
REQ-021 SHALL, when the input FIFO is non-empty (registered state) and any req_in bit is high, grant exactly one core by round-robin and pop one word.
REQ-022 SHALL register a grant at edge N and drive core_data and core_valid[grant] for exactly one cycle after edge N (latency 1).
REQ-023 SHALL, after granting core i, give highest priority to core (i+1) mod NCORES; with no grant the pointer holds.
REQ-024 SHALL issue no grant when the FIFO is empty, even if a push occurs in the same cycle (no bypass); requests stay pending.
REQ-025 SHALL treat req_in as level; a core holding req_in high across its core_valid cycle is eligible again under normal rotation.
REQ-026 SHALL, when output FIFO is not full and any out_en bit is high, accept the word from io_out of one core by an independent round-robin pointer, push it, and pulse out_ack for that core in the following cycle.
REQ-027 SHALL never accept the same core twice before its out_ack; a core holds out_en and io_out stable until out_ack.
REQ-028 SHALL present the output FIFO head on out_data with out_valid = !out_empty, and pop on out_valid && out_ready.
REQ-029 SHALL permit simultaneous push and pop on either FIFO; occupancy is unchanged, and a push at full is excluded by the registered full flag.
REQ-030 SHALL wrap FIFO pointers modulo depth; level counts 0..depth inclusive.

Reset
REQ-031 SHALL, with rst high at an edge: empty both FIFOs, zero both round-robin pointers, core_valid=0, out_ack=0, core_data=0, levels=0.
REQ-032 SHALL force in_ready=0 and out_valid=0 while rst is high; both assert per REQ-020/REQ-028 from the first cycle after release.
REQ-033 SHALL discard in-flight grants and acknowledges on reset mid-operation; no strobe follows reset.

Structure
REQ-034 SHALL take parameter defaults and the clog2 helper from shared package multicore_pkg.
REQ-035 SHALL instantiate sub-module hub_fifo (synchronous FWFT FIFO, parameters WIDTH and DEPTH) twice; arbitration is inline.

Verification
REQ-036 SHALL verify that pushing 5,-3,7 and then raising req_in=4'b0001 for 3 cycles yields core_valid[0] with 5,-3,7 on consecutive cycles and in_level 3→0.
REQ-037 SHALL verify that 4 queued words and req_in=4'b1111 held produce grants in order 0,1,2,3, then pointer=0.
REQ-038 SHALL verify that with in_level=0, req_in=4'b0010 and a simultaneous push of 9, core_valid stays low in that cycle and core 1 receives 9 one cycle later.
REQ-039 SHALL verify that with out_ready=0, filling 8 results leaves out_level=8 and out_ack silent, and that raising out_ready drains them in acceptance order.
REQ-040 SHALL verify that asserting rst with both FIFOs half-full clears the levels to 0 and emits no strobe, and that in_ready=1 on the cycle after release.
